ps2_scan_receiver: RTL
======================

Name: ps2_scan_receiver

Overview:
- PS/2 keyboard receiver: deserialises device-to-host frames on ps2_clk/ps2_data and resolves E0/F0 prefixes.
- Delivers one completed scan code per got_data pulse.
- Feeds the time/date adjust counters, which consume scan_code with got_data (0x73 increment, 0x72 decrement).
- Sits between the board PS/2 pins and the adjust-counter bank.

Parameters:
- FILTER_LEN, 4: consecutive identical samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- TIMEOUT_W, 16: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_data  in  1  raw PS/2 data line, asynchronous
- rx_en  in  1  receive enable; low aborts and holds idle
- scan_code  out  8  last delivered scan code
- got_data  out  1  one-cycle strobe, scan_code/flags valid
- break_flag  out  1  delivered code was preceded by F0
- ext_flag  out  1  delivered code was preceded by E0
- parity_err  out  1  one-cycle strobe on a bad parity or stop bit
- busy  out  1  frame in progress (FSM not IDLE)

Behaviour:
- Reset: scan_code=0, got_data=0, break_flag=0, ext_flag=0, parity_err=0, busy=0.
  - Reset also clears FSM (IDLE), shift register, bit counter, pending prefixes and timeout counter.
  - Reset mid-frame discards the partial frame.
- Input conditioning: 2-FF synchroniser on both lines.
  - ps2_clk filter: output flips only after FILTER_LEN consecutive equal synchronised samples; filter resets to 1.
  - fall = one-cycle pulse on a filtered 1->0 transition.
  - Data is sampled (synchronised value) only in cycles where fall=1.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen on fall only, except abort/timeout.
  - IDLE: on fall, data=0 goes to DATA with bitcnt=0; data=1 is a false start and stays IDLE.
  - DATA: shift in LSB first; after 8th bit go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: frame valid iff stop=1 AND XOR(8 data bits, parity)=1 (odd). Always return to IDLE.
- Valid-frame decode (outputs registered; strobe is high the cycle after the stop-bit fall):
  - byte=E0: set ext_pend; no strobe.
  - byte=F0: set brk_pend; no strobe.
  - Other byte: scan_code<=byte, ext_flag<=ext_pend, break_flag<=brk_pend, got_data=1 for 1 cycle, then clear both pending flags.
- Invalid frame: parity_err=1 for 1 cycle; ext_pend and brk_pend cleared; scan_code and flags unchanged.
- Timeout: counter clears on every fall and in IDLE, otherwise increments.
  - At TIMEOUT_CYCLES-1 while not IDLE: go to IDLE, discard the frame, clear pending flags, no strobe.
- rx_en=0: FSM forced to IDLE, partial frame and pending flags dropped; outputs hold; synchroniser/filter keep running.
- got_data and parity_err are never high in the same cycle. Strobes never last more than one cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro PS2_MAKE_ONLY_EN.
- Defined: codes whose brk_pend=1 are consumed silently (no got_data; scan_code/flags unchanged, pending flags cleared). Only key presses reach the counters.
- Undefined: break codes are delivered with break_flag=1.

Decomposition:
- Package ps2_pkg:
  - State enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Key codes KEY_UP=8'h75, KEY_DOWN=8'h72, KEY_RIGHT=8'h74, KEY_LEFT=8'h6B, KEY_PGUP=8'h7D, KEY_PGDN=8'h7A, KEY_INC=8'h73.
- Sub-module ps2_line_filter: synchronisers, FILTER_LEN glitch filter, fall pulse and synchronised data.

Test Plan:
- Frame 0x73 (parity 0, stop 1) -> one got_data pulse; scan_code=0x73, break_flag=0, ext_flag=0, parity_err=0.
- Frames E0,F0,72 -> exactly one pulse, scan_code=0x72, ext_flag=1, break_flag=1.
  - With PS2_MAKE_ONLY_EN: no pulse, scan_code unchanged.
- Frame 0x1C with parity bit inverted -> parity_err pulse; no got_data; scan_code keeps previous 0x72.
  - Same result for stop bit=0.
- ps2_clk low glitch of FILTER_LEN-1 cycles mid-DATA -> no bit shifted; the following frame 0x74 is received correctly.
- Start + 5 bits, then idle lines -> busy drops exactly TIMEOUT_CYCLES cycles after the last fall, no strobes; next frame 0x6B is received correctly.
- rst asserted after 4 data bits -> all outputs 0 next cycle; next frame 0x75 gives scan_code=0x75 with one pulse.
  - Repeat with rx_en=0 instead of rst: outputs hold, frame dropped.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_PGUP  = 8'h7D;
  localparam logic [7:0] KEY_PGDN  = 8'h7A;
  localparam logic [7:0] KEY_INC   = 8'h73;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches ps2_clk and emits a one-cycle
// pulse on each filtered falling edge with the data sample aligned to it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_filt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
      data_s    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      // Delayed one cycle so data_s lines up with the registered fall pulse.
      data_s    <= data_sync[1];
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix resolution.
// Define PS2_MAKE_ONLY_EN to silently drop break (F0-prefixed) codes.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] scan_code,
  output logic       got_data,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       parity_err,
  output logic       busy
);

  logic                 fall;
  logic                 data_s;
  ps2_state_e           state, state_n;
  logic [7:0]           shift;
  logic [2:0]           bitcnt;
  logic                 par_bit;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 ext_pend, brk_pend;
  logic                 timeout, abort, frame_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  assign timeout  = (state != IDLE) && (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign abort    = !rx_en || timeout;
  assign frame_ok = data_s && parity_ok(shift, par_bit);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_n = DATA;
        DATA:    if (bitcnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame datapath, prefix tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      bitcnt     <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      scan_code  <= '0;
      got_data   <= 1'b0;
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      got_data   <= 1'b0;
      parity_err <= 1'b0;
      if (state == IDLE || fall) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;

      if (abort) begin
        shift    <= '0;
        bitcnt   <= '0;
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (fall) begin
        case (state)
          IDLE:   bitcnt <= '0;
          DATA: begin
            shift  <= {data_s, shift[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          PARITY: par_bit <= data_s;
          STOP: begin
            if (!frame_ok) begin
              parity_err <= 1'b1;
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
            end else if (shift == PS2_EXT) begin
              ext_pend <= 1'b1;
            end else if (shift == PS2_BRK) begin
              brk_pend <= 1'b1;
            end else begin
`ifdef PS2_MAKE_ONLY_EN
              if (!brk_pend) begin
                scan_code  <= shift;
                ext_flag   <= ext_pend;
                break_flag <= 1'b0;
                got_data   <= 1'b1;
              end
`else
              scan_code  <= shift;
              ext_flag   <= ext_pend;
              break_flag <= brk_pend;
              got_data   <= 1'b1;
`endif
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
